// File: rtl/cpuc_branch_unit.sv
// cpuc_branch_unit: owns the CPUC program counter. Accepts one branch/step op
// per handshake, registers the equality flag from the compare stage, resolves
// taken/not-taken one cycle later, and pulses flush_out for one cycle after a
// taken branch so fetch can drop the wrong-path word.
module cpuc_branch_unit #(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid_in,
    output logic                  op_ready_out,
    input  logic [1:0]            br_op_in,
    input  logic [ADDR_WIDTH-1:0] br_target_in,
    input  logic [DATA_WIDTH-1:0] eq_result_in,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  flush_out,
    output logic [CNT_WIDTH-1:0]  taken_cnt_out,
    output logic                  eq_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_STEP = 2'b00,
        OP_JMP  = 2'b01,
        OP_JEQ  = 2'b10,
        OP_JNE  = 2'b11
    } br_op_t;

    localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state_q,  state_d;
    br_op_t                  op_q,     op_d;
    logic [ADDR_WIDTH-1:0]   target_q, target_d;
    logic                    eq_flag_q, eq_flag_d;
    logic [ADDR_WIDTH-1:0]   pc_q,     pc_d;
    logic                    ready_q,  ready_d;
    logic                    flush_q,  flush_d;
    logic [CNT_WIDTH-1:0]    cnt_q,    cnt_d;
    logic                    err_q,    err_d;
    logic                    taken;
    logic                    eq_all_ones;
    logic                    eq_all_zero;

    assign eq_all_ones = &eq_result_in;
    assign eq_all_zero = ~|eq_result_in;

    // Next-state and next-output computation for the IDLE/EXEC/FLUSH sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        target_d  = target_q;
        eq_flag_d = eq_flag_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        taken     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid_in && ready_q) begin
                    op_d      = br_op_t'(br_op_in);
                    target_d  = br_target_in;
                    // A malformed word (neither all-ones nor zero) reads as "not equal".
                    eq_flag_d = eq_all_ones;
                    err_d     = err_q | (~eq_all_ones & ~eq_all_zero);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_STEP: taken = 1'b0;
                    OP_JMP:  taken = 1'b1;
                    OP_JEQ:  taken = eq_flag_q;
                    OP_JNE:  taken = ~eq_flag_q;
                    default: taken = 1'b0;
                endcase
                // Step wraps modulo 2^ADDR_WIDTH; a wrap is not a branch.
                pc_d = taken ? target_q : pc_q + ADDR_WIDTH'(1);
                if (taken && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                state_d = taken ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ready_d = (state_d == ST_IDLE);
        flush_d = (state_d == ST_FLUSH);
    end

    // State and output registers; synchronous reset discards any pending op.
    always_ff @(posedge clk) begin
        // NOTE: reset here is synchronous active-high, so it is sampled only on the clock edge.
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_STEP;
            target_q  <= '0;
            eq_flag_q <= 1'b0;
            pc_q      <= PC_RST;
            ready_q   <= 1'b1;
            flush_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= state_d;
            op_q      <= op_d;
            target_q  <= target_d;
            eq_flag_q <= eq_flag_d;
            pc_q      <= pc_d;
            ready_q   <= ready_d;
            flush_q   <= flush_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign op_ready_out  = ready_q;
    assign pc_out        = pc_q;
    assign flush_out     = flush_q;
    assign taken_cnt_out = cnt_q;
    assign eq_err_out    = err_q;

endmodule

// File: tb/tb_cpuc_branch_unit.sv
// Self-checking bench for cpuc_branch_unit: directed scenarios followed by
// random ops, checked against a small behavioural PC/counter/error model.
module tb_cpuc_branch_unit;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid_in;
    logic          op_ready_out;
    logic [1:0]    br_op_in;
    logic [AW-1:0] br_target_in;
    logic [DW-1:0] eq_result_in;
    logic [AW-1:0] pc_out;
    logic          flush_out;
    logic [CW-1:0] taken_cnt_out;
    logic          eq_err_out;

    int vectors = 0;
    int errs    = 0;

    // Reference model state
    logic [AW-1:0] pc_m;
    int            cnt_m;
    bit            err_m;

    cpuc_branch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (0),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid_in  (op_valid_in),
        .op_ready_out (op_ready_out),
        .br_op_in     (br_op_in),
        .br_target_in (br_target_in),
        .eq_result_in (eq_result_in),
        .pc_out       (pc_out),
        .flush_out    (flush_out),
        .taken_cnt_out(taken_cnt_out),
        .eq_err_out   (eq_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pc_m  = '0;
        cnt_m = 0;
        err_m = 1'b0;
    endtask

    // Apply one op starting at a negedge; checks every cycle until the unit is idle again.
    task automatic do_op(input logic [1:0] op, input logic [AW-1:0] tgt, input logic [DW-1:0] eq);
        bit            taken;
        logic [AW-1:0] exp_pc;
        int            n;
        n = 0;
        while (op_ready_out !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_op", op_ready_out, 1);

        op_valid_in  = 1'b1;
        br_op_in     = op;
        br_target_in = tgt;
        eq_result_in = eq;

        // Reference: taken rule from the op table, all-ones word means equal.
        taken = (op == 2'b01) ||
                (op == 2'b10 && eq == 8'hFF) ||
                (op == 2'b11 && eq != 8'hFF);
        if (eq != 8'h00 && eq != 8'hFF) err_m = 1'b1;
        exp_pc = taken ? tgt : AW'(pc_m + 1);
        if (taken && cnt_m < CMAX) cnt_m++;

        @(posedge clk);
        #1;
        // Garbage with valid high while busy must be ignored.
        br_op_in     = 2'($urandom);
        br_target_in = AW'($urandom);
        eq_result_in = 8'h3C;

        @(negedge clk);
        check("exec_ready", op_ready_out, 0);
        check("exec_flush", flush_out, 0);
        check("exec_pc_hold", pc_out, pc_m);

        @(negedge clk);
        op_valid_in = 1'b0;
        check("pc_result", pc_out, exp_pc);
        check("flush_result", flush_out, taken);
        check("ready_result", op_ready_out, !taken);
        check("taken_cnt", taken_cnt_out, cnt_m);
        check("eq_err", eq_err_out, err_m);

        if (taken) begin
            @(negedge clk);
            check("flush_done", flush_out, 0);
            check("ready_after_flush", op_ready_out, 1);
            check("pc_after_flush", pc_out, exp_pc);
        end
        pc_m = exp_pc;
    endtask

    initial begin
        logic [DW-1:0] eq_r;
        rst          = 1'b1;
        op_valid_in  = 1'b0;
        br_op_in     = '0;
        br_target_in = '0;
        eq_result_in = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_pc", pc_out, 0);
        check("rst_ready", op_ready_out, 1);
        check("rst_flush", flush_out, 0);
        check("rst_cnt", taken_cnt_out, 0);
        check("rst_err", eq_err_out, 0);
        rst = 1'b0;

        // Idle with valid low changes nothing.
        repeat (3) @(negedge clk);
        check("idle_pc", pc_out, 0);

        // Three back-to-back steps.
        do_op(2'b00, 8'h99, 8'h00);
        do_op(2'b00, 8'h99, 8'hFF);
        do_op(2'b00, 8'h99, 8'h00);

        // jeq taken / not taken, jne taken.
        do_op(2'b01, 8'h10, 8'h00);
        do_op(2'b10, 8'h40, 8'hFF);
        do_op(2'b01, 8'h10, 8'h00);
        do_op(2'b10, 8'h40, 8'h00);
        do_op(2'b01, 8'h10, 8'h00);
        do_op(2'b11, 8'h40, 8'h00);
        do_op(2'b11, 8'h20, 8'hFF);

        // Malformed compare word: not equal, sticky error.
        do_op(2'b10, 8'h80, 8'h5A);
        do_op(2'b00, 8'h00, 8'h00);

        // PC wrap on step.
        do_op(2'b01, 8'hFF, 8'hFF);
        do_op(2'b00, 8'h12, 8'h00);

        // Jump to pc+1 still taken.
        do_op(2'b01, AW'(pc_m + 1), 8'h00);

        // Random ops (counter saturates along the way).
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       eq_r = 8'h00;
                1:       eq_r = 8'hFF;
                2:       eq_r = 8'hFF;
                default: eq_r = DW'($urandom);
            endcase
            do_op(2'($urandom), AW'($urandom), eq_r);
        end

        // Reset during FLUSH.
        op_valid_in  = 1'b1;
        br_op_in     = 2'b01;
        br_target_in = 8'h33;
        eq_result_in = 8'h5A;
        @(posedge clk);
        #1 op_valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_flush", flush_out, 1);
        check("pre_rst_pc", pc_out, 8'h33);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("flush_rst_pc", pc_out, 0);
        check("flush_rst_flush", flush_out, 0);
        check("flush_rst_ready", op_ready_out, 1);
        check("flush_rst_cnt", taken_cnt_out, 0);
        check("flush_rst_err", eq_err_out, 0);

        // Reset during EXEC discards the pending op.
        op_valid_in  = 1'b1;
        br_op_in     = 2'b01;
        br_target_in = 8'h77;
        eq_result_in = 8'hFF;
        @(posedge clk);
        #1 op_valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("exec_rst_pc", pc_out, 0);
        check("exec_rst_ready", op_ready_out, 1);
        @(negedge clk);
        check("exec_rst_discard_pc", pc_out, 0);
        check("exec_rst_discard_flush", flush_out, 0);
        check("exec_rst_cnt", taken_cnt_out, 0);

        do_op(2'b00, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
